// File: rtl/multicycle_control.sv
// rtl/multicycle_control.sv - multi-cycle MIPS control FSM; optional trap state under MCTRL_TRAP_EN
module multicycle_control #(
  parameter int ALUOP_W  = 3,
  parameter int WAIT_MAX = 15
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [5:0]         opcode,
  input  logic [5:0]         funct,
  input  logic               zero,
  input  logic               mem_ready,
  output logic               ir_write,
  output logic               pc_en,
  output logic [1:0]         pc_src,
  output logic               i_or_d,
  output logic               mem_read,
  output logic               mem_write,
  output logic               mem2reg,
  output logic               reg_dst,
  output logic               reg_write,
  output logic               alu_src_a,
  output logic [1:0]         alu_src_b,
  output logic [ALUOP_W-1:0] alu_op,
  output logic               sign_xtend,
  output logic               mem_err,
  output logic               trap,
  output logic [2:0]         state
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_TRAP   = 3'd5
  } state_e;

  typedef enum logic [2:0] {
    C_NOP, C_R, C_JR, C_IMM, C_BR, C_J, C_LD, C_ST
  } class_e;

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_SUB  = 3'b001;
  localparam logic [2:0] OP_SHC  = 3'b010;
  localparam logic [2:0] OP_AND  = 3'b011;
  localparam logic [2:0] OP_OR   = 3'b100;
  localparam logic [2:0] OP_XOR  = 3'b101;
  localparam logic [2:0] OP_NOR  = 3'b110;
  localparam logic [2:0] OP_NONE = 3'b111;

  // Counter value on the last tolerated cycle without mem_ready
  localparam logic [7:0] WAIT_LAST = 8'(WAIT_MAX - 1);

  state_e     state_q, state_d;
  class_e     class_q, class_d;
  logic [2:0] exec_op_q, exec_op_d;
  logic       bne_q, bne_d;
  logic       zext_q, zext_d;
  logic [7:0] wait_q, wait_d;

  logic       dec_ok;
  class_e     dec_class;
  logic [2:0] dec_op;
  logic       dec_zext;
  logic       timeout;
  logic [2:0] alu3;

  // Classify the instruction in IR; dec_ok=0 flags an unsupported opcode/funct
  always_comb begin
    dec_ok    = 1'b1;
    dec_class = C_NOP;
    dec_op    = OP_NONE;
    dec_zext  = 1'b0;
    casez (opcode)
      6'b000000: begin
        dec_class = C_R;
        casez (funct)
          6'b001000:            begin dec_class = C_JR; dec_op = OP_ADD; end
          6'b10000?:            dec_op = OP_ADD;
          6'b10001?:            dec_op = OP_SUB;
          6'b000???, 6'b1010??: dec_op = OP_SHC;
          6'b100100:            dec_op = OP_AND;
          6'b100101:            dec_op = OP_OR;
          6'b100110:            dec_op = OP_XOR;
          6'b100111:            dec_op = OP_NOR;
          default:              begin dec_ok = 1'b0; dec_class = C_NOP; end
        endcase
      end
      6'b000010: dec_class = C_J;
      6'b00010?: begin dec_class = C_BR;  dec_op = OP_SUB; end
      6'b00100?: begin dec_class = C_IMM; dec_op = OP_ADD; end
      6'b00101?: begin dec_class = C_IMM; dec_op = OP_SHC; end
      6'b001100: begin dec_class = C_IMM; dec_op = OP_AND; dec_zext = 1'b1; end
      6'b001101: begin dec_class = C_IMM; dec_op = OP_OR;  dec_zext = 1'b1; end
      6'b001110: begin dec_class = C_IMM; dec_op = OP_XOR; dec_zext = 1'b1; end
      6'b001111: begin dec_class = C_IMM; dec_op = OP_SHC; dec_zext = 1'b1; end
      6'b100???: begin dec_class = C_LD;  dec_op = OP_ADD; end
      6'b101???: begin dec_class = C_ST;  dec_op = OP_ADD; end
      default:   dec_ok = 1'b0;
    endcase
  end

  // Next-state, latched instruction class and memory-wait watchdog
  always_comb begin
    state_d   = state_q;
    class_d   = class_q;
    exec_op_d = exec_op_q;
    bne_d     = bne_q;
    zext_d    = zext_q;
    wait_d    = 8'd0;
    timeout   = ((state_q == S_FETCH) || (state_q == S_MEM)) && !mem_ready &&
                (wait_q == WAIT_LAST);
    case (state_q)
      S_FETCH: begin
        if (mem_ready)     state_d = S_DECODE;
        else if (!timeout) wait_d  = wait_q + 8'd1;
      end
      S_DECODE: begin
        class_d   = dec_class;
        exec_op_d = dec_op;
        bne_d     = opcode[0];
        zext_d    = dec_zext;
        if (dec_ok) state_d = S_EXEC;
`ifdef MCTRL_TRAP_EN
        else        state_d = S_TRAP;
`else
        else        state_d = S_FETCH;
`endif
      end
      S_EXEC: begin
        case (class_q)
          C_R, C_IMM: state_d = S_WB;
          C_LD, C_ST: state_d = S_MEM;
          default:    state_d = S_FETCH;
        endcase
      end
      S_MEM: begin
        if (mem_ready)     state_d = (class_q == C_LD) ? S_WB : S_FETCH;
        else if (timeout)  state_d = S_FETCH;
        else               wait_d  = wait_q + 8'd1;
      end
      default: state_d = S_FETCH;
    endcase
  end

  // State and latched-decode registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_FETCH;
      class_q   <= C_NOP;
      exec_op_q <= OP_NONE;
      bne_q     <= 1'b0;
      zext_q    <= 1'b0;
      wait_q    <= 8'd0;
    end else begin
      state_q   <= state_d;
      class_q   <= class_d;
      exec_op_q <= exec_op_d;
      bne_q     <= bne_d;
      zext_q    <= zext_d;
      wait_q    <= wait_d;
    end
  end

  // Datapath controls from state and latched class; held at reset values while rst_n is low
  always_comb begin
    ir_write   = 1'b0;
    pc_en      = 1'b0;
    pc_src     = 2'b00;
    i_or_d     = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    mem2reg    = 1'b0;
    reg_dst    = 1'b0;
    reg_write  = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = 2'b00;
    alu3       = OP_NONE;
    sign_xtend = 1'b0;
    mem_err    = 1'b0;
    trap       = 1'b0;
    if (rst_n) begin
      case (state_q)
        S_FETCH: begin
          mem_read  = 1'b1;
          alu_src_b = 2'b01;
          alu3      = OP_ADD;
          ir_write  = mem_ready;
          pc_en     = mem_ready;
          mem_err   = timeout;
        end
        S_DECODE: begin
          alu_src_b  = 2'b11;
          alu3       = OP_ADD;
          sign_xtend = 1'b1;
        end
        S_EXEC: begin
          case (class_q)
            C_R: begin
              alu_src_a = 1'b1;
              alu3      = exec_op_q;
            end
            C_JR: begin
              pc_en     = 1'b1;
              alu_src_a = 1'b1;
              alu3      = OP_ADD;
            end
            C_IMM: begin
              alu_src_a  = 1'b1;
              alu_src_b  = 2'b10;
              alu3       = exec_op_q;
              sign_xtend = !zext_q;
            end
            C_BR: begin
              alu_src_a = 1'b1;
              alu3      = OP_SUB;
              pc_src    = 2'b01;
              pc_en     = bne_q ? !zero : zero;
            end
            C_J: begin
              pc_en  = 1'b1;
              pc_src = 2'b10;
            end
            C_LD, C_ST: begin
              alu_src_a  = 1'b1;
              alu_src_b  = 2'b10;
              alu3       = OP_ADD;
              sign_xtend = 1'b1;
            end
            default: ;
          endcase
        end
        S_MEM: begin
          i_or_d    = 1'b1;
          mem_read  = (class_q == C_LD);
          mem_write = (class_q == C_ST);
          mem_err   = timeout;
        end
        S_WB: begin
          reg_write = 1'b1;
          reg_dst   = (class_q == C_R);
          mem2reg   = (class_q == C_LD);
        end
`ifdef MCTRL_TRAP_EN
        S_TRAP: begin
          trap   = 1'b1;
          pc_en  = 1'b1;
          pc_src = 2'b11;
        end
`endif
        default: ;
      endcase
    end
    alu_op      = '0;
    alu_op[2:0] = alu3;
  end

  assign state = state_q;

endmodule

// File: tb/tb_multicycle_control.sv
// tb/tb_multicycle_control.sv - scoreboard bench for multicycle_control
module tb_multicycle_control;

  localparam int WAIT_MAX = 4;

  logic       clk;
  logic       rst_n;
  logic [5:0] opcode;
  logic [5:0] funct;
  logic       zero;
  logic       mem_ready;
  logic       ir_write, pc_en, i_or_d, mem_read, mem_write, mem2reg, reg_dst, reg_write;
  logic       alu_src_a, sign_xtend, mem_err, trap;
  logic [1:0] pc_src, alu_src_b;
  logic [2:0] alu_op;
  logic [2:0] state;

  multicycle_control #(.ALUOP_W(3), .WAIT_MAX(WAIT_MAX)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct), .zero(zero),
    .mem_ready(mem_ready), .ir_write(ir_write), .pc_en(pc_en), .pc_src(pc_src),
    .i_or_d(i_or_d), .mem_read(mem_read), .mem_write(mem_write), .mem2reg(mem2reg),
    .reg_dst(reg_dst), .reg_write(reg_write), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .alu_op(alu_op), .sign_xtend(sign_xtend),
    .mem_err(mem_err), .trap(trap), .state(state)
  );

  typedef struct packed {
    logic       ir_write;
    logic       pc_en;
    logic [1:0] pc_src;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       mem2reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_op;
    logic       sign_xtend;
    logic       mem_err;
    logic       trap;
  } ctl_t;

  typedef struct {
    string      tag;
    bit         rn;
    bit         rdy;
    bit         zr;
    logic [5:0] op;
    logic [5:0] fn;
    logic [2:0] st;
    ctl_t       val;
    ctl_t       care;
  } exp_t;

  exp_t       sb[$];
  int         checks = 0;
  int         errors = 0;
  logic [5:0] cur_op = 6'd0;
  logic [5:0] cur_fn = 6'd0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%h want=%h", tag, got, want);
    end
  endtask

  function automatic ctl_t strobes();
    ctl_t m = '0;
    m.ir_write  = 1'b1;
    m.pc_en     = 1'b1;
    m.mem_read  = 1'b1;
    m.mem_write = 1'b1;
    m.reg_write = 1'b1;
    m.mem_err   = 1'b1;
    m.trap      = 1'b1;
    return m;
  endfunction

  task automatic push(input string tag, input bit rn, input bit rdy, input bit zr,
                      input logic [2:0] st, input ctl_t v, input ctl_t c);
    exp_t e;
    e.tag  = tag;
    e.rn   = rn;
    e.rdy  = rdy;
    e.zr   = zr;
    e.op   = cur_op;
    e.fn   = cur_fn;
    e.st   = st;
    e.val  = v;
    e.care = c | strobes();
    sb.push_back(e);
  endtask

  task automatic p_reset(input string tag);
    ctl_t v = '0;
    v.alu_op = 3'b111;
    push(tag, 1'b0, 1'b1, 1'b0, 3'd0, v, '1);
  endtask

  task automatic p_fetch(input string tag, input bit rdy, input bit err);
    ctl_t v = '0;
    ctl_t c = '0;
    v.mem_read  = 1'b1;
    v.alu_src_b = 2'b01;
    v.alu_op    = 3'b000;
    v.ir_write  = rdy;
    v.pc_en     = rdy;
    v.mem_err   = err;
    c.i_or_d    = 1'b1;
    c.alu_src_a = 1'b1;
    c.alu_src_b = '1;
    c.alu_op    = '1;
    if (rdy) c.pc_src = '1;
    push(tag, 1'b1, rdy, 1'b0, 3'd0, v, c);
  endtask

  task automatic p_decode(input string tag);
    ctl_t v = '0;
    ctl_t c = '0;
    v.alu_src_b = 2'b11;
    v.alu_op    = 3'b000;
    c.alu_src_b = '1;
    c.alu_op    = '1;
    push(tag, 1'b1, 1'b1, 1'b0, 3'd1, v, c);
  endtask

  // ALU-style EXEC: operand selects and op, optionally sign_xtend
  task automatic p_exec_alu(input string tag, input logic [1:0] b, input logic [2:0] op,
                            input bit care_sx, input bit sx);
    ctl_t v = '0;
    ctl_t c = '0;
    v.alu_src_a  = 1'b1;
    v.alu_src_b  = b;
    v.alu_op     = op;
    v.sign_xtend = sx;
    c.alu_src_a  = 1'b1;
    c.alu_src_b  = '1;
    c.alu_op     = '1;
    c.sign_xtend = care_sx;
    push(tag, 1'b1, 1'b1, 1'b0, 3'd2, v, c);
  endtask

  task automatic p_exec_br(input string tag, input bit zr, input bit taken);
    ctl_t v = '0;
    ctl_t c = '0;
    v.alu_src_a = 1'b1;
    v.alu_src_b = 2'b00;
    v.alu_op    = 3'b001;
    v.pc_src    = 2'b01;
    v.pc_en     = taken;
    c.alu_src_a = 1'b1;
    c.alu_src_b = '1;
    c.alu_op    = '1;
    c.pc_src    = '1;
    push(tag, 1'b1, 1'b1, zr, 3'd2, v, c);
  endtask

  task automatic p_mem(input string tag, input bit rdy, input bit wr, input bit err);
    ctl_t v = '0;
    ctl_t c = '0;
    v.i_or_d    = 1'b1;
    v.mem_read  = !wr;
    v.mem_write = wr;
    v.mem_err   = err;
    c.i_or_d    = 1'b1;
    push(tag, 1'b1, rdy, 1'b0, 3'd3, v, c);
  endtask

  task automatic p_wb(input string tag, input bit rdst, input bit m2r);
    ctl_t v = '0;
    ctl_t c = '0;
    v.reg_write = 1'b1;
    v.reg_dst   = rdst;
    v.mem2reg   = m2r;
    c.reg_dst   = 1'b1;
    c.mem2reg   = 1'b1;
    push(tag, 1'b1, 1'b1, 1'b0, 3'd4, v, c);
  endtask

  // Drive one cycle of stimulus after the edge, compare mid-cycle
  task automatic step();
    exp_t e;
    ctl_t o;
    e = sb.pop_front();
    @(posedge clk);
    #1;
    rst_n     = e.rn;
    mem_ready = e.rdy;
    zero      = e.zr;
    opcode    = e.op;
    funct     = e.fn;
    @(negedge clk);
    o = {ir_write, pc_en, pc_src, i_or_d, mem_read, mem_write, mem2reg, reg_dst,
         reg_write, alu_src_a, alu_src_b, alu_op, sign_xtend, mem_err, trap};
    check_value({e.tag, "/state"}, 32'(state), 32'(e.st));
    check_value({e.tag, "/ctl"}, 32'(o & e.care), 32'(e.val & e.care));
  endtask

  initial begin
    rst_n     = 1'b0;
    mem_ready = 1'b0;
    zero      = 1'b0;
    opcode    = 6'd0;
    funct     = 6'd0;

    p_reset("rst0");
    p_reset("rst1");

    // R-type add, sub, nor: 4 cycles each
    cur_op = 6'b000000; cur_fn = 6'b100000;
    p_fetch("add.f", 1, 0); p_decode("add.d"); p_exec_alu("add.x", 2'b00, 3'b000, 0, 0); p_wb("add.w", 1, 0);
    cur_fn = 6'b100010;
    p_fetch("sub.f", 1, 0); p_decode("sub.d"); p_exec_alu("sub.x", 2'b00, 3'b001, 0, 0); p_wb("sub.w", 1, 0);
    cur_fn = 6'b100111;
    p_fetch("nor.f", 1, 0); p_decode("nor.d"); p_exec_alu("nor.x", 2'b00, 3'b110, 0, 0); p_wb("nor.w", 1, 0);

    // lw with three wait cycles; ready arrives exactly at the watchdog limit
    cur_op = 6'b100011; cur_fn = 6'd0;
    p_fetch("lw.f", 1, 0); p_decode("lw.d"); p_exec_alu("lw.x", 2'b10, 3'b000, 1, 1);
    p_mem("lw.m0", 0, 0, 0); p_mem("lw.m1", 0, 0, 0); p_mem("lw.m2", 0, 0, 0);
    p_mem("lw.m3", 1, 0, 0); p_wb("lw.w", 0, 1);

    // beq/bne with both zero values: 3 cycles each
    cur_op = 6'b000100;
    p_fetch("beq1.f", 1, 0); p_decode("beq1.d"); p_exec_br("beq1.x", 1, 1);
    p_fetch("beq0.f", 1, 0); p_decode("beq0.d"); p_exec_br("beq0.x", 0, 0);
    cur_op = 6'b000101;
    p_fetch("bne1.f", 1, 0); p_decode("bne1.d"); p_exec_br("bne1.x", 1, 0);
    p_fetch("bne0.f", 1, 0); p_decode("bne0.d"); p_exec_br("bne0.x", 0, 1);

    // j and jr
    cur_op = 6'b000010;
    p_fetch("j.f", 1, 0); p_decode("j.d");
    begin
      ctl_t v = '0;
      ctl_t c = '0;
      v.pc_en = 1'b1; v.pc_src = 2'b10; c.pc_src = '1;
      push("j.x", 1'b1, 1'b1, 1'b0, 3'd2, v, c);
    end
    cur_op = 6'b000000; cur_fn = 6'b001000;
    p_fetch("jr.f", 1, 0); p_decode("jr.d");
    begin
      ctl_t v = '0;
      ctl_t c = '0;
      v.pc_en = 1'b1; v.pc_src = 2'b00; v.alu_src_a = 1'b1; v.alu_src_b = 2'b00; v.alu_op = 3'b000;
      c.pc_src = '1; c.alu_src_a = 1'b1; c.alu_src_b = '1; c.alu_op = '1;
      push("jr.x", 1'b1, 1'b1, 1'b0, 3'd2, v, c);
    end

    // Immediates: ori zero-extends, addi sign-extends; both write rt
    cur_op = 6'b001101; cur_fn = 6'd0;
    p_fetch("ori.f", 1, 0); p_decode("ori.d"); p_exec_alu("ori.x", 2'b10, 3'b100, 1, 0); p_wb("ori.w", 0, 0);
    cur_op = 6'b001000;
    p_fetch("addi.f", 1, 0); p_decode("addi.d"); p_exec_alu("addi.x", 2'b10, 3'b000, 1, 1); p_wb("addi.w", 0, 0);

    // Fetch watchdog: error on the 4th idle cycle, then counter restarts and ready wins at the limit
    cur_op = 6'b101011;
    p_fetch("wd.f0", 0, 0); p_fetch("wd.f1", 0, 0); p_fetch("wd.f2", 0, 0); p_fetch("wd.f3", 0, 1);
    p_fetch("wd.g0", 0, 0); p_fetch("wd.g1", 0, 0); p_fetch("wd.g2", 0, 0); p_fetch("wd.g3", 1, 0);

    // sw interrupted by reset while waiting in MEM
    p_decode("sw.d"); p_exec_alu("sw.x", 2'b10, 3'b000, 1, 1); p_mem("sw.m0", 0, 1, 0);
    p_reset("sw.rst"); p_reset("sw.rst2");
    p_fetch("sw.after", 0, 0);

    // lw abandoned by the MEM watchdog: no write-back, straight to FETCH
    cur_op = 6'b100011;
    p_fetch("lwto.f", 1, 0); p_decode("lwto.d"); p_exec_alu("lwto.x", 2'b10, 3'b000, 1, 1);
    p_mem("lwto.m0", 0, 0, 0); p_mem("lwto.m1", 0, 0, 0); p_mem("lwto.m2", 0, 0, 0);
    p_mem("lwto.m3", 0, 0, 1); p_fetch("lwto.next", 0, 0);

    // Illegal opcode
    cur_op = 6'b111111;
    p_fetch("ill.f", 1, 0); p_decode("ill.d");
`ifdef MCTRL_TRAP_EN
    begin
      ctl_t v = '0;
      ctl_t c = '0;
      v.trap = 1'b1; v.pc_en = 1'b1; v.pc_src = 2'b11; c.pc_src = '1;
      push("ill.trap", 1'b1, 1'b1, 1'b0, 3'd5, v, c);
    end
`endif
    p_fetch("ill.next", 0, 0);

    while (sb.size() > 0) step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
